voyaverquehagoconel_pwm: RTL and testbench
==========================================

Name: voyaverquehagoconel_pwm

Overview:
- Free-running, 12-bit, period-programmable PWM generator for the ADC/PWM datapath.
- The period is set by `load`; the high time is set by `compare`, typically a sampled ADC code.
- `load` and `compare` are captured into shadow registers only at period boundaries. Changing them mid-period therefore never produces a glitch or a truncated pulse.

Parameters:
- WIDTH, 12, bit width of the counter, `load`, `compare` and both shadow registers.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-low reset (0 = reset asserted).
- load  input  WIDTH  terminal count; PWM period = load+1 clocks.
- compare  input  WIDTH  duty threshold; high time = min(compare, load+1) clocks per period.
- pwm_out  output  1  registered PWM waveform.

Behaviour:
- State: counter cnt[WIDTH-1:0], shadow period per_sh, shadow threshold cmp_sh, output register pwm_out.
- Reset (rst=0, asynchronous, independent of clk): cnt=0, per_sh=0, cmp_sh=0, pwm_out=0. These values are held while rst=0.
- Terminal condition: term = (cnt == per_sh).
- On each rising clk edge with rst=1:
  - If term: cnt<=0, per_sh<=load, cmp_sh<=compare.
  - Else: cnt<=cnt+1. per_sh and cmp_sh are unchanged.
  - pwm_out <= (cnt < cmp_sh), unsigned compare using the current (pre-edge) cnt and cmp_sh.
- First period after reset release:
  - per_sh=0, so term is true on the first edge and the shadows capture load/compare then.
  - That edge drives pwm_out=0 (0<0 false).
  - The first full period starts at the following edge.
- Latency:
  - pwm_out lags the counter by one clock.
  - A new load/compare value takes effect at the first period boundary after it is applied, then appears on pwm_out one clock later.
- Within a period (cnt 0..per_sh), pwm_out is high for exactly min(cmp_sh, per_sh+1) consecutive clocks, starting with the clock after cnt=0. It is low for the remainder of the period.
- Boundaries:
  - cmp_sh=0: pwm_out constantly 0.
  - cmp_sh > per_sh: pwm_out constantly 1 (100% duty, no low pulse, no glitch across the wrap).
  - per_sh=0: period is 1 clock; pwm_out=1 if cmp_sh>=1, else 0.
  - load=4095, compare=4095: high 4095 clocks, low 1 clock per 4096-clock period.
- The counter never exceeds per_sh and wrap-around is only via the term path; there is no WIDTH-bit overflow case.
- Inputs may change at any time. Only the values present on the terminal edge are used.
- Reset mid-period: output goes to 0 immediately (asynchronously), and the sequence restarts as after power-up.
- No combinational path from any input to pwm_out.

Test Plan:
- Reset: hold rst=0 for 5 clocks with load=4095, compare=100 -> pwm_out=0 throughout. Releasing rst gives one capture clock with pwm_out=0, then pwm_out high 100 clocks, low 3996, with period 4096.
- Duty sweep at load=4095: apply compare = 170, 42, 250, 190, 182, 255, 170, each held for 4096 clocks -> the measured high time per period equals the compare value exactly.
  - Each new value is effective from the period after it is applied.
  - No period ever shows a mixed or truncated high time.
- Extremes at load=4095: compare=0 -> pwm_out stays 0. compare=4095 -> high 4095, low 1. Then set load=9, compare=15 -> pwm_out stays 1 continuously after the boundary.
- Small period: load=0, compare=1 -> pwm_out constantly 1. load=3, compare=2 -> repeating pattern 1,1,0,0.
- Mid-period change: with load=99, compare=50, change compare to 10 at cnt=20 -> current period still high 50. The next period is high 10. Change load to 49 mid-period -> the current period still lasts 100 clocks; the next lasts 50.
- Asynchronous reset mid-high-phase: drop rst between clock edges -> pwm_out falls to 0 without waiting for a clock edge. The post-release behaviour is identical to the first scenario.

Source files
------------

// File: rtl/voyaverquehagoconel_pwm_if.sv
// ---------------------------------------------------------------------------
// voyaverquehagoconel_pwm_if
// Groups the PWM generator's data signals. The master drives the period and
// duty inputs and observes the waveform. The slave (the PWM core) consumes
// the period and duty inputs and drives the waveform.
//   load    : terminal count; PWM period = load+1 clocks
//   compare : duty threshold; high time = min(compare, load+1) clocks
//   pwm_out : registered PWM waveform
// ---------------------------------------------------------------------------
interface voyaverquehagoconel_pwm_if #(
  parameter int WIDTH = 12
);
  logic [WIDTH-1:0] load;
  logic [WIDTH-1:0] compare;
  logic             pwm_out;

  modport master (
    output load,
    output compare,
    input  pwm_out
  );

  modport slave (
    input  load,
    input  compare,
    output pwm_out
  );
endinterface

// File: rtl/voyaverquehagoconel_pwm.sv
// ---------------------------------------------------------------------------
// voyaverquehagoconel_pwm
// Free-running, period-programmable PWM generator. The period (load) and the
// duty threshold (compare) are copied into shadow registers only when the
// counter reaches its terminal value. This means changes made mid-period
// never truncate or glitch the pulse that is currently being generated.
// Ports:
//   clk : system clock; all state updates on its rising edge
//   rst : asynchronous reset, active low
//   bus : slave side of voyaverquehagoconel_pwm_if (load, compare -> pwm_out)
// ---------------------------------------------------------------------------
module voyaverquehagoconel_pwm #(
  parameter int WIDTH = 12
) (
  input  logic                          clk,
  input  logic                          rst,
  voyaverquehagoconel_pwm_if.slave      bus
);

  logic [WIDTH-1:0] cnt_r;
  logic [WIDTH-1:0] per_sh_r;
  logic [WIDTH-1:0] cmp_sh_r;
  logic             pwm_out_r;

  logic             term_s;
  logic [WIDTH-1:0] cnt_nxt_s;
  logic [WIDTH-1:0] per_sh_nxt_s;
  logic [WIDTH-1:0] cmp_sh_nxt_s;
  logic             pwm_nxt_s;

  // The counter never exceeds per_sh_r, so equality is the only wrap path.
  assign term_s = (cnt_r == per_sh_r);

  // Next-state logic: wrap and capture the shadows at the terminal count, otherwise count up.
  always_comb begin
    cnt_nxt_s    = cnt_r;
    per_sh_nxt_s = per_sh_r;
    cmp_sh_nxt_s = cmp_sh_r;
    if (term_s) begin
      cnt_nxt_s    = {WIDTH{1'b0}};
      per_sh_nxt_s = bus.load;
      cmp_sh_nxt_s = bus.compare;
    end else begin
      cnt_nxt_s    = cnt_r + WIDTH'(1);
      per_sh_nxt_s = per_sh_r;
      cmp_sh_nxt_s = cmp_sh_r;
    end
    // Uses the pre-edge count and threshold. After reset both are zero, so
    // the capture edge drives a low output.
    pwm_nxt_s = (cnt_r < cmp_sh_r);
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_r     <= {WIDTH{1'b0}};
      per_sh_r  <= {WIDTH{1'b0}};
      cmp_sh_r  <= {WIDTH{1'b0}};
      pwm_out_r <= 1'b0;
    end else begin
      cnt_r     <= cnt_nxt_s;
      per_sh_r  <= per_sh_nxt_s;
      cmp_sh_r  <= cmp_sh_nxt_s;
      pwm_out_r <= pwm_nxt_s;
    end
  end

  assign bus.pwm_out = pwm_out_r;

endmodule

// File: tb/tb_voyaverquehagoconel_pwm.sv
// ---------------------------------------------------------------------------
// tb_voyaverquehagoconel_pwm
// Scoreboard bench for the PWM generator. On every rising edge, a
// period-level waveform generator pushes the expected pwm_out level for that
// edge. On each falling edge, the bench pops that level and compares it with
// the DUT output.
// ---------------------------------------------------------------------------
module tb_voyaverquehagoconel_pwm;

  localparam int WIDTH = 12;

  logic clk;
  logic rst;

  voyaverquehagoconel_pwm_if #(.WIDTH(WIDTH)) pwm_if ();

  voyaverquehagoconel_pwm #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (pwm_if)
  );

  int test_cnt = 0;
  int fail_cnt = 0;

  // Expected waveform generator state: position in the period, period
  // length, and high time for the period in progress.
  int   pos;
  int   plen;
  int   hi;
  logic exp_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int got, input int exp);
    test_cnt++;
    if (got !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Waveform generator. Each period is hi high clocks followed by the
  // remaining low clocks. The period length and high time come from the
  // inputs present on the last edge of the previous period. Reset acts as a
  // one-clock period with zero high time, which yields the capture clock.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      pos  <= 0;
      plen <= 1;
      hi   <= 0;
      exp_q.delete();
    end else begin
      exp_q.push_back(pos < hi);
      if (pos + 1 == plen) begin
        pos  <= 0;
        plen <= int'(pwm_if.load) + 1;
        hi   <= (int'(pwm_if.compare) < int'(pwm_if.load) + 1) ?
                int'(pwm_if.compare) : int'(pwm_if.load) + 1;
      end else begin
        pos <= pos + 1;
      end
    end
  end

  // Compare the DUT output against the scoreboard, away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      check_val("rst_hold", int'(pwm_if.pwm_out), 0);
    end else if (exp_q.size() > 0) begin
      check_val("pwm", int'(pwm_if.pwm_out), int'(exp_q.pop_front()));
    end
  end

  task automatic run(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Wait (bounded) until the generator reaches the given period length and position.
  task automatic wait_pos(input string tag, input int tplen, input int tpos, input int budget);
    int found;
    found = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (plen == tplen && pos == tpos) begin
        found = 1;
        break;
      end
    end
    check_val(tag, found, 1);
  endtask

  task automatic reset_seq();
    rst = 1'b0;
    run(5);
    rst = 1'b1;
  endtask

  int sweep[7] = '{170, 42, 250, 190, 182, 255, 170};

  initial begin
    rst            = 1'b0;
    pwm_if.load    = 12'd4095;
    pwm_if.compare = 12'd100;

    // Power-up reset, then one capture clock and a full 4096-clock period.
    reset_seq();
    run(4096 + 8);

    // Duty sweep at the maximum period.
    foreach (sweep[k]) begin
      pwm_if.compare = WIDTH'(sweep[k]);
      run(4096);
    end

    // Extremes: 0% duty, 4095/4096 duty, then compare above the period.
    pwm_if.compare = 12'd0;
    run(2 * 4096);
    pwm_if.compare = 12'd4095;
    run(2 * 4096);
    pwm_if.load    = 12'd9;
    pwm_if.compare = 12'd15;
    run(4096 + 100);

    // Small periods.
    pwm_if.load    = 12'd0;
    pwm_if.compare = 12'd1;
    run(50);
    pwm_if.load    = 12'd3;
    pwm_if.compare = 12'd2;
    run(40);

    // Mid-period changes of compare and then load.
    pwm_if.load    = 12'd99;
    pwm_if.compare = 12'd50;
    wait_pos("wait_cnt20", 100, 20, 400);
    pwm_if.compare = 12'd10;
    run(250);
    wait_pos("wait_cnt30", 100, 30, 200);
    pwm_if.load = 12'd49;
    run(300);

    // Asynchronous reset in the middle of a high phase.
    pwm_if.load    = 12'd4095;
    pwm_if.compare = 12'd100;
    wait_pos("wait_high", 4096, 50, 500);
    check_val("pre_rst_high", int'(pwm_if.pwm_out), 1);
    #2;
    rst = 1'b0;
    #1;
    check_val("async_rst", int'(pwm_if.pwm_out), 0);
    run(5);
    rst = 1'b1;
    run(4096 + 8);

    $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
    $finish;
  end

endmodule
